// File: rtl/mdiv_pkg.sv
// rtl/mdiv_pkg.sv - shared types and sizes for the iterative multiply/divide unit
package mdiv_pkg;

  localparam int MDIV_W     = 32;
  localparam int MDIV_CNT_W = $clog2(MDIV_W);

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdiv_state_t;

endpackage

// File: rtl/mdiv_unit_if.sv
// rtl/mdiv_unit_if.sv - M-stage request/result bundle between the pipeline and the mul/div unit
interface mdiv_unit_if #(parameter int W = mdiv_pkg::MDIV_W);

  logic         START;
  logic [1:0]   OP;
  logic [W-1:0] SRC_A;
  logic [W-1:0] SRC_B;
  logic         MTHI;
  logic         MTLO;
  logic         ABORT;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         BUSY;

  modport master (
    output START, OP, SRC_A, SRC_B, MTHI, MTLO, ABORT,
    input  HI, LO, BUSY
  );

  modport slave (
    input  START, OP, SRC_A, SRC_B, MTHI, MTLO, ABORT,
    output HI, LO, BUSY
  );

endinterface

// File: rtl/mdiv_step.sv
// rtl/mdiv_step.sv - one combinational shift-add or restoring-divide iteration
module mdiv_step #(
  parameter int W = 32
) (
  input  logic         is_div,
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] work_i,
  input  logic [W-1:0] opnd_i,
  output logic [W-1:0] acc_o,
  output logic [W-1:0] work_o
);

  logic [W-1:0] addend;
  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W:0]   diff;
  logic         ge;

  assign addend  = work_i[0] ? opnd_i : '0;
  assign sum     = {1'b0, acc_i} + {1'b0, addend};
  assign shifted = {acc_i, work_i[W-1]};
  assign diff    = shifted - {1'b0, opnd_i};
  // remainder < divisor before the shift, so a set top bit of diff means a borrow
  assign ge      = ~diff[W];

  always_comb begin
    acc_o  = acc_i;
    work_o = work_i;
    if (is_div) begin
      acc_o  = ge ? diff[W-1:0] : shifted[W-1:0];
      work_o = {work_i[W-2:0], ge};
    end else begin
      acc_o  = sum[W:1];
      work_o = {sum[0], work_i[W-1:1]};
    end
  end

endmodule

// File: rtl/mdiv_unit.sv
// rtl/mdiv_unit.sv - iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO and abort
module mdiv_unit
  import mdiv_pkg::*;
#(
  parameter int W = MDIV_W
) (
  input  logic        CLK,
  input  logic        RESET,
  mdiv_unit_if.slave  bus
);

  localparam int CW = $clog2(W);

  mdiv_state_t state_q, state_d;
  mdiv_op_t    op_q, op_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_a_q, sign_a_d;
  logic          sign_b_q, sign_b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  work_q, work_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;

  logic [W-1:0]  step_acc, step_work;
  logic          start_signed;
  logic [W-1:0]  mag_a, mag_b;
  logic          is_signed, q_neg, r_neg;
  logic [2*W-1:0] prod;

  mdiv_step #(.W(W)) u_step (
    .is_div (op_q[1]),
    .acc_i  (acc_q),
    .work_i (work_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .work_o (step_work)
  );

  assign start_signed = ~bus.OP[0];
  assign mag_a = (start_signed && bus.SRC_A[W-1]) ? -bus.SRC_A : bus.SRC_A;
  assign mag_b = (start_signed && bus.SRC_B[W-1]) ? -bus.SRC_B : bus.SRC_B;

  assign is_signed = ~op_q[0];
  assign q_neg     = is_signed && (sign_a_q ^ sign_b_q);
  assign r_neg     = is_signed && sign_a_q;
  assign prod      = {acc_q, work_q};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          op_d     = mdiv_op_t'(bus.OP);
          sign_a_d = bus.SRC_A[W-1];
          sign_b_d = bus.SRC_B[W-1];
          acc_d    = '0;
          work_d   = bus.OP[1] ? mag_a : mag_b;
          opnd_d   = bus.OP[1] ? mag_b : mag_a;
          cnt_d    = CW'(W - 1);
          state_d  = RUN;
          busy_d   = 1'b1;
        end else begin
          if (bus.MTHI) hi_d = bus.SRC_A;
          if (bus.MTLO) lo_d = bus.SRC_A;
        end
      end
      RUN: begin
        acc_d  = step_acc;
        work_d = step_work;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        if (op_q[1]) begin
          lo_d = q_neg ? -work_q : work_q;
          hi_d = r_neg ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = q_neg ? -prod : prod;
        end
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // flush wins over start, iteration and the final write
    if (bus.ABORT) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      op_q     <= MULT;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_mdiv_unit.sv
// tb/tb_mdiv_unit.sv - directed vector bench for mdiv_unit
module tb_mdiv_unit;

  logic clk;
  logic rst;

  mdiv_unit_if #(.W(32)) bus ();

  mdiv_unit #(.W(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];
  int   n_cmp;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, input int abort_at,
                        output int cnt, output logic hold_ok, output logic rose);
    logic [31:0] pre_hi, pre_lo;
    pre_hi  = bus.HI;
    pre_lo  = bus.LO;
    hold_ok = 1'b1;
    @(negedge clk);
    bus.OP = op; bus.SRC_A = a; bus.SRC_B = b; bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    rose = bus.BUSY;
    cnt  = 0;
    while (bus.BUSY && cnt < 200) begin
      cnt++;
      if (bus.HI !== pre_hi || bus.LO !== pre_lo) hold_ok = 1'b0;
      if (cnt == inject_at) begin
        bus.START = 1'b1; bus.MTHI = 1'b1; bus.MTLO = 1'b1;
        bus.OP = 2'b01; bus.SRC_A = 32'hDEADBEEF; bus.SRC_B = 32'h1;
      end
      if (cnt == abort_at) bus.ABORT = 1'b1;
      @(negedge clk);
      bus.START = 1'b0; bus.MTHI = 1'b0; bus.MTLO = 1'b0; bus.ABORT = 1'b0;
    end
  endtask

  initial begin
    int          cnt;
    logic        hold_ok;
    logic        rose;
    logic [31:0] pre_hi, pre_lo;

    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{"multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult_m7x3", 2'b00, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{"div_m7d2",  2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu_100d7",2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{"divu_by0",  2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[5] = '{"div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{"mult_minsq",2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{"div_7dm2",  2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{"multu_x16", 2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[9] = '{"div_m8by0", 2'b10, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'h00000001};

    bus.START = 1'b0; bus.OP = 2'b00; bus.SRC_A = '0; bus.SRC_B = '0;
    bus.MTHI = 1'b0; bus.MTLO = 1'b0; bus.ABORT = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_hi", bus.HI, 32'h0);
    check("reset_lo", bus.LO, 32'h0);
    check("reset_busy", {31'b0, bus.BUSY}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, -1, cnt, hold_ok, rose);
      check({vecs[i].name, "_rise"}, {31'b0, rose}, 32'h1);
      check({vecs[i].name, "_busy_cycles"}, cnt, 32'd33);
      check({vecs[i].name, "_hold"}, {31'b0, hold_ok}, 32'h1);
      check({vecs[i].name, "_hi"}, bus.HI, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, bus.LO, vecs[i].exp_lo);
    end

    // MT writes in IDLE
    bus.MTHI = 1'b1; bus.SRC_A = 32'hAAAA0000;
    @(negedge clk);
    bus.MTHI = 1'b0;
    check("mthi_hi", bus.HI, 32'hAAAA0000);
    pre_lo = bus.LO;
    bus.MTLO = 1'b1; bus.SRC_A = 32'h00005555;
    @(negedge clk);
    bus.MTLO = 1'b0;
    check("mtlo_lo", bus.LO, 32'h00005555);
    check("mtlo_hi_kept", bus.HI, 32'hAAAA0000);
    bus.MTHI = 1'b1; bus.MTLO = 1'b1; bus.SRC_A = 32'h00000077;
    @(negedge clk);
    bus.MTHI = 1'b0; bus.MTLO = 1'b0;
    check("mt_both_hi", bus.HI, 32'h77);
    check("mt_both_lo", bus.LO, 32'h77);

    // START with MTHI in IDLE: the start wins
    @(negedge clk);
    bus.OP = 2'b01; bus.SRC_A = 32'd2; bus.SRC_B = 32'd3; bus.START = 1'b1; bus.MTHI = 1'b1;
    @(negedge clk);
    bus.START = 1'b0; bus.MTHI = 1'b0;
    check("start_vs_mt_hi", bus.HI, 32'h77);
    check("start_vs_mt_busy", {31'b0, bus.BUSY}, 32'h1);
    cnt = 0;
    while (bus.BUSY && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("start_vs_mt_res_hi", bus.HI, 32'h0);
    check("start_vs_mt_res_lo", bus.LO, 32'd6);

    // START and MT writes while busy are ignored
    run_op(2'b00, 32'hFFFFFFFE, 32'd3, 5, -1, cnt, hold_ok, rose);
    check("busy_ign_cycles", cnt, 32'd33);
    check("busy_ign_hi", bus.HI, 32'hFFFFFFFF);
    check("busy_ign_lo", bus.LO, 32'hFFFFFFFA);
    @(negedge clk);
    check("busy_ign_no_restart", {31'b0, bus.BUSY}, 32'h0);

    // ABORT at busy cycle 10
    pre_hi = bus.HI;
    pre_lo = bus.LO;
    run_op(2'b11, 32'd1000, 32'd9, -1, 10, cnt, hold_ok, rose);
    check("abort_cycles", cnt, 32'd10);
    check("abort_hi", bus.HI, pre_hi);
    check("abort_lo", bus.LO, pre_lo);

    // ABORT with START in IDLE
    bus.OP = 2'b11; bus.SRC_A = 32'd5; bus.SRC_B = 32'd1; bus.START = 1'b1; bus.ABORT = 1'b1;
    @(negedge clk);
    bus.START = 1'b0; bus.ABORT = 1'b0;
    check("abort_start_busy", {31'b0, bus.BUSY}, 32'h0);
    check("abort_start_lo", bus.LO, pre_lo);

    // asynchronous reset at busy cycle 20
    bus.OP = 2'b11; bus.SRC_A = 32'd77; bus.SRC_B = 32'd5; bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    cnt = 1;
    while (bus.BUSY && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("pre_reset_busy", {31'b0, bus.BUSY}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_hi", bus.HI, 32'h0);
    check("async_rst_lo", bus.LO, 32'h0);
    check("async_rst_busy", {31'b0, bus.BUSY}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", {31'b0, bus.BUSY}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdiv_unit.md
Name: mdiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS core, located in the M stage.
- Executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers. Also services MTHI and MTLO writes.
- Drives the busy flag that the hazard unit uses to stall MFHI/MFLO at M.
- HI/LO feed the M-stage coprocessor/MFHL read mux.

Parameters:
- W, 32: operand width. HI and LO are each W bits. Iteration count equals W.

Ports:
- CLK  in  1  core clock
- RESET  in  1  asynchronous, active-high reset
- START  in  1  single-cycle start pulse. The caller gates it with the pipeline stall, so one instruction produces one pulse.
- OP  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SRC_A  in  W  rs operand (multiplicand / dividend)
- SRC_B  in  W  rt operand (multiplier / divisor)
- MTHI  in  1  write SRC_A to HI
- MTLO  in  1  write SRC_A to LO
- ABORT  in  1  exception flush: kill the in-flight operation
- HI  out  W  HI register
- LO  out  W  LO register
- BUSY  out  1  operation in flight; registered

Behaviour:
- Reset (async): state=IDLE, HI=0, LO=0, BUSY=0, iteration counter=0. RESET mid-operation discards the operation immediately.
- FSM states: IDLE, RUN, FIX.
- IDLE with START=1 at edge t:
  - Latch operand magnitudes. For signed ops, take the absolute value; for unsigned ops, use the raw value.
  - Latch sign flags, OP, and counter=W-1.
  - Go to RUN. BUSY=1 from t.
- RUN: one iteration per cycle. When counter=0, go to FIX; otherwise decrement.
  - Multiply: shift-add on a 2W-bit {acc, multiplier} register, one multiplier bit per cycle, LSB first.
  - Divide: restoring division. Shift the remainder left, bring in the next dividend bit MSB first, subtract the divisor when the remainder >= divisor, and shift the quotient bit in.
- FIX: one cycle, then IDLE with BUSY=0.
  - Multiply: {HI,LO} = product, two's-complement negated over 2W bits if the operand signs differ (signed only).
  - Divide: LO = quotient, negated if the operand signs differ. HI = remainder, negated if the dividend is negative (signed only).
- Latency: START sampled at edge t gives BUSY=1 for edges t..t+W+1. HI/LO are updated at edge t+W+1; BUSY=0 after that edge. For W=32: 33 busy cycles, result visible in the cycle after the last busy cycle.
- HI/LO hold their old values throughout RUN. Intermediate state lives only in internal registers.
- Boundary cases:
  - Divide by zero: no trap, full latency, result is whatever the algorithm produces.
    - DIVU x/0: LO=all ones, HI=x.
    - DIV x/0: magnitude result, then sign fix per the FIX rules.
  - DIV -2^(W-1) / -1: LO=0x80000000, HI=0. No trap.
- Conflict and abort rules:
  - START while BUSY: ignored.
  - MTHI/MTLO while BUSY: ignored.
  - START and MTHI/MTLO together in IDLE: START wins and the MT write is dropped.
  - MTHI and MTLO together: both written.
  - ABORT (synchronous): the next state is IDLE and BUSY drops after that edge. HI/LO are unchanged, and a FIX write in the same cycle is suppressed.
  - ABORT together with START in IDLE: no start.
- No combinational paths from inputs to outputs.

Decomposition:
- Package mdiv_pkg:
  - mdiv_op_t enum: MULT, MULTU, DIV, DIVU
  - mdiv_state_t enum: IDLE, RUN, FIX
  - localparam for the counter width, $clog2(W)
- Sub-module mdiv_step: purely combinational single iteration. Inputs are op class, the working registers and the divisor/multiplicand; outputs are the next working registers.
- mdiv_unit holds the FSM, counter, sign flags, HI/LO registers and MT write logic.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001. BUSY rises at the start edge and falls exactly 33 cycles later.
- MULT -7 × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/7 → LO=14, HI=2.
- DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0xAAAA0000 then MTLO 0x5555 in IDLE → HI and LO updated on the next edge. Start a MULT, then assert MTHI and a second START while BUSY → both ignored, first result intact.
- Start DIVU, ABORT at busy cycle 10 → BUSY=0 after that edge, HI/LO keep their pre-start values. Assert RESET at busy cycle 20 of a new op → HI=LO=0, BUSY=0 immediately.
